sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like bus port between the fetch side (inst) and the execute/memory side (data).
- The memory stage consumes data_rdata and data_data_ok from this block.
- Grants one request per cycle with fixed data priority and a grant lock. Records the source of each accepted request in an in-order tag FIFO, and routes each data_ok/rdata back to the owning requester.
- Sits between the pipeline and the AXI bridge.

Parameters:
OUTSTANDING, 4, max accepted-but-unanswered requests, 1..8; tag FIFO depth
PTR_W, 2, FIFO pointer width, clog2(OUTSTANDING)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_req  in  1  fetch request; held until inst_addr_ok
inst_addr  in  32  fetch address
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch data returned this cycle
inst_rdata  out  32  fetch data
data_req  in  1  load/store request; held until data_addr_ok
data_wr  in  1  1=store
data_size  in  2  0=byte, 1=half, 2=word
data_addr  in  32  data address
data_wstrb  in  4  store byte strobes
data_wdata  in  32  store data
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  load data / store ack returned
data_rdata  out  32  load data
bus_req  out  1  shared bus request
bus_wr  out  1  muxed wr (0 for inst)
bus_size  out  2  muxed size (2 for inst)
bus_addr  out  32  muxed address
bus_wstrb  out  4  muxed strobes (0 for inst)
bus_wdata  out  32  muxed wdata (0 for inst)
bus_addr_ok  in  1  bus accepted request
bus_data_ok  in  1  bus returns response
bus_rdata  in  32  response data
err_unexp  out  1  sticky: bus_data_ok seen with empty FIFO

Behaviour:
- One clock domain (clk). reset is synchronous, active-high.
- Reset clears: FIFO (rd_ptr=wr_ptr=0, count=0), lock=0, lock_src=0, err_unexp=0.
- Outputs after reset: bus_req=0, all *_addr_ok=0, all *_data_ok=0.
- Grant (combinational):
  - If lock=1: grant = lock_src.
  - Else if data_req: grant = data (1).
  - Else if inst_req: grant = inst (0).
  - Else: none.
- bus_req = (grant requester's req) && (count < OUTSTANDING).
  - When full, bus_req=0 even if bus_data_ok pops in the same cycle. No full-bypass.
- Bus payload muxed from the granted side. All bus payload fields read 0 when bus_req=0.
- inst_addr_ok = bus_addr_ok && bus_req && grant==inst. data_addr_ok is the same with grant==data.
- Lock:
  - bus_req=1 and bus_addr_ok=0: next lock=1, lock_src=grant. A later data_req cannot preempt a pending inst request.
  - Handshake (bus_req && bus_addr_ok): next lock=0.
  - Locked requester drops req (illegal per protocol): lock clears next cycle.
- Push: on bus_req && bus_addr_ok, write grant tag at wr_ptr, wr_ptr+1 (wraps at OUTSTANDING), count+1.
- Pop/route:
  - bus_data_ok with count>0: tag at rd_ptr selects the target. Assert inst_data_ok or data_data_ok in the same cycle (combinational, zero latency). rd_ptr+1 with wrap, count-1.
  - inst_rdata = data_rdata = bus_rdata, always passed through.
  - Store responses pop like loads.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push-to-pop same cycle: not allowed. A response can arrive no earlier than the cycle after its addr_ok.
- bus_data_ok with count==0: ignored (no *_data_ok, no pointer change). err_unexp sets to 1 and holds until reset.
- Responses return in acceptance order. The bus guarantees in-order return.
- Reset mid-transaction: FIFO and lock discarded. Late bus_data_ok after reset triggers err_unexp.
- Latency: request to bus is 0 cycles (combinational); response routing is 0 cycles.

Test Plan:
- Single fetch: inst_req=1, addr=0x1c000000, bus_addr_ok=1 in cycle 0, then bus_data_ok=1 with rdata=0x02800c0c in cycle 2 -> inst_addr_ok=1 in cycle 0; inst_data_ok=1 and inst_rdata=0x02800c0c in cycle 2; data_data_ok=0.
- Simultaneous: inst_req=data_req=1, data store addr=0x1c008000, wstrb=0xF, bus_addr_ok=1 -> bus_wr=1, addr=0x1c008000, data_addr_ok=1, inst_addr_ok=0. Next cycle inst is granted.
- Lock: inst_req=1 with bus_addr_ok=0 for 3 cycles, data_req rises in cycle 1 -> bus_addr stays the inst address until bus_addr_ok. Data is granted the cycle after.
- Ordering/full: 4 accepted (inst, data, inst, data) with no responses -> 5th request sees bus_req=0. Then 4 bus_data_ok -> data_ok pulses go to inst, data, inst, data in order, and bus_req reasserts after the first pop.
- Simultaneous push+pop at count=2 -> count stays 2, routing correct.
- Unexpected response: bus_data_ok=1 with empty FIFO -> no *_data_ok, err_unexp=1 sticky. Reset asserted mid-flight with 2 outstanding -> count=0, err_unexp=0, bus_req=0 next cycle.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch and data sides with fixed data priority,
// a grant lock for stalled requests, and an in-order tag FIFO for routing responses.
module sram_bus_arbiter #(
    parameter int unsigned OUTSTANDING = 4,
    parameter int unsigned PTR_W       = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,

    output logic        err_unexp
);

    localparam int unsigned CntW = PTR_W + 1;
    localparam logic [CntW-1:0]  CntMax  = CntW'(OUTSTANDING);
    localparam logic [PTR_W-1:0] PtrLast = PTR_W'(OUTSTANDING - 1);

    logic                   lock_q, lock_d;
    logic                   lock_src_q, lock_src_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]        count_q, count_d;
    logic                   err_q, err_d;
    logic [OUTSTANDING-1:0] tags_q;

    logic grant_data;
    logic grant_req;
    logic push;
    logic pop;
    logic pop_tag;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    // A locked grant keeps its owner even if the other side now has higher priority.
    always_comb begin
        grant_data = 1'b0;
        grant_req  = 1'b0;
        if (lock_q) begin
            grant_data = lock_src_q;
            grant_req  = lock_src_q ? data_req : inst_req;
        end else if (data_req) begin
            grant_data = 1'b1;
            grant_req  = 1'b1;
        end else if (inst_req) begin
            grant_req  = 1'b1;
        end
    end

    assign bus_req = grant_req && (count_q < CntMax);
    assign push    = bus_req && bus_addr_ok;
    assign pop     = bus_data_ok && (count_q != '0);
    assign pop_tag = tags_q[rd_ptr_q];

    always_comb begin
        bus_wr    = 1'b0;
        bus_size  = 2'd0;
        bus_addr  = 32'h0;
        bus_wstrb = 4'h0;
        bus_wdata = 32'h0;
        if (bus_req) begin
            if (grant_data) begin
                bus_wr    = data_wr;
                bus_size  = data_size;
                bus_addr  = data_addr;
                bus_wstrb = data_wstrb;
                bus_wdata = data_wdata;
            end else begin
                bus_size  = 2'd2;
                bus_addr  = inst_addr;
            end
        end
    end

    assign inst_addr_ok = push && !grant_data;
    assign data_addr_ok = push && grant_data;
    assign inst_data_ok = pop && !pop_tag;
    assign data_data_ok = pop && pop_tag;
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;
    assign err_unexp    = err_q;

    always_comb begin
        lock_d     = bus_req && !bus_addr_ok;
        lock_src_d = lock_d ? grant_data : lock_src_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        err_d      = err_q || (bus_data_ok && (count_q == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q     <= 1'b0;
            lock_src_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    // Tag storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            tags_q[wr_ptr_q] <= grant_data;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench: directed literal cases followed by randomized traffic checked
// every cycle against a queue-based model of the arbiter.
module tb_sram_bus_arbiter;

    localparam int OUT = 4;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        err_unexp;

    sram_bus_arbiter #(.OUTSTANDING(OUT), .PTR_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_addr     (bus_addr),
        .bus_wstrb    (bus_wstrb),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata),
        .err_unexp    (err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: owners of accepted requests in acceptance order (1 = data side).
    bit tagq[$];
    bit m_lock, m_src, m_err, model_ok;
    bit last_inst_hs, last_data_hs;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Who owns the bus this cycle, and whether a request reaches the bus.
    function automatic void m_eval(output bit g, output bit br);
        bit v;
        v = 1'b0;
        g = 1'b0;
        if (m_lock) begin
            g = m_src;
            v = 1'b1;
        end else if (data_req) begin
            g = 1'b1;
            v = 1'b1;
        end else if (inst_req) begin
            v = 1'b1;
        end
        br = v && (g ? data_req : inst_req) && (tagq.size() < OUT);
    endfunction

    always @(negedge clk) begin
        bit g, br, pop;
        if (model_ok) begin
            m_eval(g, br);
            pop = bus_data_ok && (tagq.size() > 0);
            check("bus_req", bus_req, br);
            check("bus_wr", bus_wr, br && g && data_wr);
            check("bus_size", bus_size, !br ? 32'd0 : (g ? data_size : 32'd2));
            check("bus_addr", bus_addr, !br ? 32'd0 : (g ? data_addr : inst_addr));
            check("bus_wstrb", bus_wstrb, (br && g) ? data_wstrb : 4'h0);
            check("bus_wdata", bus_wdata, (br && g) ? data_wdata : 32'h0);
            check("inst_addr_ok", inst_addr_ok, br && bus_addr_ok && !g);
            check("data_addr_ok", data_addr_ok, br && bus_addr_ok && g);
            check("inst_data_ok", inst_data_ok, pop && (tagq[0] == 1'b0));
            check("data_data_ok", data_data_ok, pop && (tagq[0] == 1'b1));
            check("inst_rdata", inst_rdata, bus_rdata);
            check("data_rdata", data_rdata, bus_rdata);
            check("err_unexp", err_unexp, m_err);
        end
    end

    always @(posedge clk) begin
        bit g, br, pop;
        if (reset) begin
            tagq.delete();
            m_lock = 1'b0;
            m_src = 1'b0;
            m_err = 1'b0;
            last_inst_hs = 1'b0;
            last_data_hs = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            m_eval(g, br);
            pop = bus_data_ok && (tagq.size() > 0);
            if (bus_data_ok && tagq.size() == 0) m_err = 1'b1;
            last_inst_hs = br && bus_addr_ok && !g;
            last_data_hs = br && bus_addr_ok && g;
            if (pop) void'(tagq.pop_front());
            if (br && bus_addr_ok) tagq.push_back(g);
            m_lock = br && !bus_addr_ok;
            if (m_lock) m_src = g;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle();
        inst_req    = 1'b0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
    endtask

    task automatic accept(input bit is_data, input logic [31:0] a);
        nxt();
        idle();
        bus_addr_ok = 1'b1;
        if (is_data) begin
            data_req  = 1'b1;
            data_addr = a;
        end else begin
            inst_req  = 1'b1;
            inst_addr = a;
        end
    endtask

    initial begin
        model_ok = 1'b0;
        reset = 1'b1;
        idle();
        inst_addr = '0; data_size = 2'd2; data_addr = '0;
        data_wstrb = '0; data_wdata = '0; bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        smp();
        check("rst bus_req", bus_req, 0);
        check("rst inst_addr_ok", inst_addr_ok, 0);
        check("rst data_data_ok", data_data_ok, 0);
        check("rst err_unexp", err_unexp, 0);

        // Single fetch.
        accept(1'b0, 32'h1c000000);
        smp();
        check("fetch addr_ok", inst_addr_ok, 1);
        check("fetch bus_addr", bus_addr, 32'h1c000000);
        nxt(); idle();
        nxt(); bus_data_ok = 1'b1; bus_rdata = 32'h02800c0c;
        smp();
        check("fetch data_ok", inst_data_ok, 1);
        check("fetch rdata", inst_rdata, 32'h02800c0c);
        check("fetch no data_data_ok", data_data_ok, 0);

        // Simultaneous requests: data wins, inst follows.
        nxt(); idle();
        inst_req = 1'b1; inst_addr = 32'h1c000004;
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h1c008000;
        data_wstrb = 4'hf; data_wdata = 32'hdeadbeef; bus_addr_ok = 1'b1;
        smp();
        check("simul bus_wr", bus_wr, 1);
        check("simul bus_addr", bus_addr, 32'h1c008000);
        check("simul data_addr_ok", data_addr_ok, 1);
        check("simul inst_addr_ok", inst_addr_ok, 0);
        nxt(); data_req = 1'b0; data_wr = 1'b0;
        smp();
        check("simul inst next", inst_addr_ok, 1);
        nxt(); idle(); bus_data_ok = 1'b1;
        smp();
        check("simul resp1 data", data_data_ok, 1);
        nxt();
        smp();
        check("simul resp2 inst", inst_data_ok, 1);

        // Lock: a stalled fetch keeps the bus against a later data request.
        nxt(); idle(); inst_req = 1'b1; inst_addr = 32'h1c000100;
        nxt(); data_req = 1'b1; data_addr = 32'h1c008040;
        smp();
        check("lock c1 addr", bus_addr, 32'h1c000100);
        nxt();
        smp();
        check("lock c2 addr", bus_addr, 32'h1c000100);
        nxt(); bus_addr_ok = 1'b1;
        smp();
        check("lock inst accept", inst_addr_ok, 1);
        nxt(); inst_req = 1'b0;
        smp();
        check("lock data after", data_addr_ok, 1);
        check("lock data addr", bus_addr, 32'h1c008040);
        nxt(); idle();
        bus_data_ok = 1'b1;
        nxt();
        nxt(); idle();

        // Full FIFO, no bypass, in-order routing.
        accept(1'b0, 32'h100);
        accept(1'b1, 32'h200);
        accept(1'b0, 32'h104);
        accept(1'b1, 32'h204);
        accept(1'b0, 32'h108);
        smp();
        check("full bus_req", bus_req, 0);
        check("full inst_addr_ok", inst_addr_ok, 0);
        nxt(); bus_data_ok = 1'b1;
        smp();
        check("full pop1 inst", inst_data_ok, 1);
        check("full no bypass", bus_req, 0);
        nxt();
        smp();
        check("full pop2 data", data_data_ok, 1);
        check("full reassert", bus_req, 1);
        nxt(); inst_req = 1'b0;
        smp();
        check("full pop3 inst", inst_data_ok, 1);
        nxt();
        smp();
        check("full pop4 data", data_data_ok, 1);
        nxt();
        smp();
        check("full pop5 inst", inst_data_ok, 1);
        nxt(); idle();

        // Unexpected response, then reset with two outstanding.
        nxt(); bus_data_ok = 1'b1;
        smp();
        check("unexp no inst_ok", inst_data_ok, 0);
        check("unexp no data_ok", data_data_ok, 0);
        nxt(); bus_data_ok = 1'b0;
        smp();
        check("unexp err set", err_unexp, 1);
        accept(1'b0, 32'h300);
        accept(1'b1, 32'h304);
        nxt(); idle(); reset = 1'b1;
        smp();
        check("err sticky", err_unexp, 1);
        nxt(); reset = 1'b0;
        smp();
        check("post-rst bus_req", bus_req, 0);
        check("post-rst err", err_unexp, 0);
        nxt(); bus_data_ok = 1'b1;
        smp();
        check("late resp dropped", inst_data_ok, 0);
        nxt(); bus_data_ok = 1'b0;
        smp();
        check("late resp err", err_unexp, 1);
        nxt(); reset = 1'b1;
        nxt(); reset = 1'b0;

        // Random traffic checked against the model.
        for (int i = 0; i < 4000; i++) begin
            nxt();
            if (last_inst_hs) inst_req = 1'b0;
            if (last_data_hs) data_req = 1'b0;
            if (!inst_req && ($urandom_range(0, 2) != 0)) begin
                inst_req  = 1'b1;
                inst_addr = $urandom & 32'hffff_fffc;
            end
            if (!data_req && ($urandom_range(0, 2) == 0)) begin
                data_req   = 1'b1;
                data_wr    = $urandom_range(0, 1) == 1;
                data_size  = 2'($urandom_range(0, 2));
                data_addr  = $urandom;
                data_wstrb = 4'($urandom);
                data_wdata = $urandom;
            end
            bus_addr_ok = $urandom_range(0, 1) == 1;
            bus_data_ok = (tagq.size() > 0) && ($urandom_range(0, 1) == 1);
            bus_rdata   = $urandom;
        end
        nxt(); idle();
        smp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
